uc_pila: RTL and testbench

UC_PILA -- requirements
Module: uc_pila

---
 rtl/uc_pila.sv | 149 ++++++++++++++
 tb/tb_uc_pila.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uc_pila.sv
// Control unit with a return-address stack for jal/ret and an I/O wait handshake.
// Define STACK_FAULT_EN to trap stack overflow/underflow in a sticky FAULT state.
`timescale 1ns/1ps
module uc_pila #(
  parameter int unsigned PCW   = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   Opcode,
  input  logic                         z,
  input  logic [PCW-1:0]               pc_next,
  input  logic                         io_ack,
  output logic                         s_inc,
  output logic                         s_inm,
  output logic                         we3,
  output logic                         wez,
  output logic [2:0]                   Op,
  output logic                         s_ret,
  output logic [PCW-1:0]               ret_addr,
  output logic                         pc_en,
  output logic                         io_req,
  output logic [$clog2(DEPTH+1)-1:0]   sp_count,
  output logic                         fault
);
  localparam int unsigned SPW = $clog2(DEPTH+1);
  localparam int unsigned IW  = $clog2(DEPTH);

`ifdef STACK_FAULT_EN
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [SPW-1:0]  r_sp;
  logic [PCW-1:0]  r_stack [DEPTH];
  logic            w_push, w_pop, w_full, w_empty;
  logic [IW-1:0]   w_top_idx;

  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = IW'(r_sp - 1'b1);
  assign ret_addr  = w_empty ? '0 : r_stack[w_top_idx];
  assign sp_count  = r_sp;

`ifdef STACK_FAULT_EN
  assign fault = (r_state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    s_inc       = 1'b0;
    s_inm       = 1'b0;
    we3         = 1'b0;
    wez         = 1'b0;
    Op          = '0;
    s_ret       = 1'b0;
    pc_en       = 1'b0;
    io_req      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      case (r_state)
        S_RUN: begin
          pc_en = 1'b1;
          if (Opcode[5]) begin
            s_inc = 1'b1;
            we3   = 1'b1;
            wez   = 1'b1;
            Op    = Opcode[4:2];
          end else begin
            casez (Opcode)
              6'b0001??: begin
                s_inc = 1'b1;
                s_inm = 1'b1;
                we3   = 1'b1;
              end
              6'b010000: s_inc = 1'b0;
              6'b010001: s_inc = ~z;
              6'b010010: s_inc = z;
              6'b010011: begin
                // Without fault trapping an overflowing jal still jumps; the push is dropped.
                s_inc  = 1'b0;
                w_push = !w_full;
`ifdef STACK_FAULT_EN
                if (w_full) begin
                  pc_en       = 1'b0;
                  w_state_nxt = S_FAULT;
                end
`endif
              end
              6'b010100: begin
                s_ret = 1'b1;
                w_pop = !w_empty;
`ifdef STACK_FAULT_EN
                if (w_empty) begin
                  pc_en       = 1'b0;
                  w_state_nxt = S_FAULT;
                end
`endif
              end
              6'b011000: begin
                pc_en       = 1'b0;
                io_req      = 1'b1;
                w_state_nxt = S_WAIT;
              end
              6'b011111: begin
                pc_en       = 1'b0;
                w_state_nxt = S_HALT;
              end
              default: s_inc = 1'b1;
            endcase
          end
        end
        S_WAIT: begin
          io_req = 1'b1;
          if (io_ack) begin
            pc_en       = 1'b1;
            s_inc       = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_HALT: w_state_nxt = S_HALT;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push)
        r_sp <= r_sp + 1'b1;
      else if (w_pop)
        r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_stack[IW'(r_sp)] <= pc_next;
  end
endmodule

// File: tb/tb_uc_pila.sv
// Directed self-checking bench for uc_pila (PCW=10, DEPTH=8).
`timescale 1ns/1ps
module tb_uc_pila;
  localparam int unsigned PCW   = 10;
  localparam int unsigned DEPTH = 8;

  localparam logic [5:0] OP_ALU = 6'b100100;
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LI  = 6'b000101;
  localparam logic [5:0] OP_JZ  = 6'b010001;
  localparam logic [5:0] OP_JNZ = 6'b010010;
  localparam logic [5:0] OP_JAL = 6'b010011;
  localparam logic [5:0] OP_RET = 6'b010100;
  localparam logic [5:0] OP_WT  = 6'b011000;
  localparam logic [5:0] OP_HLT = 6'b011111;

  logic           clk = 1'b0;
  logic           reset;
  logic [5:0]     Opcode;
  logic           z;
  logic [PCW-1:0] pc_next;
  logic           io_ack;
  logic           s_inc, s_inm, we3, wez, s_ret, pc_en, io_req, fault;
  logic [2:0]     Op;
  logic [PCW-1:0] ret_addr;
  logic [$clog2(DEPTH+1)-1:0] sp_count;

  int checks   = 0;
  int failures = 0;

  uc_pila #(.PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .pc_next(pc_next),
    .io_ack(io_ack), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .Op(Op), .s_ret(s_ret), .ret_addr(ret_addr), .pc_en(pc_en),
    .io_req(io_req), .sp_count(sp_count), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, then let combinational outputs settle.
  task automatic step(input logic [5:0] op, input logic zz, input logic ack,
                      input logic rst, input logic [PCW-1:0] pcn);
    @(negedge clk);
    Opcode  = op;
    z       = zz;
    io_ack  = ack;
    reset   = rst;
    pc_next = pcn;
    #1;
  endtask

  initial begin
    reset = 1'b1; Opcode = OP_ALU; z = 1'b0; io_ack = 1'b0; pc_next = '0;

    step(OP_ALU, 0, 0, 1, 0);
    step(OP_ALU, 0, 0, 1, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_we3", we3, 0);
    chk("rst_op", Op, 0);
    chk("rst_sinc", s_inc, 0);
    chk("rst_fault", fault, 0);

    step(OP_ALU, 0, 0, 0, 0);
    chk("alu_we3", we3, 1);
    chk("alu_wez", wez, 1);
    chk("alu_op", Op, 3'b001);
    chk("alu_sinc", s_inc, 1);
    chk("alu_sp", sp_count, 0);
    chk("alu_pc_en", pc_en, 1);

    step(OP_JZ, 1, 0, 0, 0);  chk("jz_z1", s_inc, 0);
    step(OP_JZ, 0, 0, 0, 0);  chk("jz_z0", s_inc, 1);
    step(OP_JNZ, 1, 0, 0, 0); chk("jnz_z1", s_inc, 1);
    step(OP_JNZ, 0, 0, 0, 0); chk("jnz_z0", s_inc, 0);
    step(OP_LI, 0, 0, 0, 0);
    chk("li_inm", s_inm, 1);
    chk("li_we3", we3, 1);
    chk("li_wez", wez, 0);
    chk("empty_ret_addr", ret_addr, 0);

    step(OP_JAL, 0, 0, 0, 10'h005);
    chk("jal1_sinc", s_inc, 0);
    chk("jal1_pc_en", pc_en, 1);
    step(OP_JAL, 0, 0, 0, 10'h00A);
    chk("jal2_sp", sp_count, 1);
    chk("jal2_top", ret_addr, 10'h005);
    step(OP_RET, 0, 0, 0, 0);
    chk("ret1_sp", sp_count, 2);
    chk("ret1_sret", s_ret, 1);
    chk("ret1_addr", ret_addr, 10'h00A);
    step(OP_RET, 0, 0, 0, 0);
    chk("ret2_sp", sp_count, 1);
    chk("ret2_addr", ret_addr, 10'h005);
    step(OP_NOP, 0, 0, 0, 0);
    chk("pop_sp", sp_count, 0);
    chk("pop_addr", ret_addr, 0);
    chk("nop_sret", s_ret, 0);
    chk("nop_sinc", s_inc, 1);

    step(OP_RET, 0, 0, 0, 0);
    chk("under_sret", s_ret, 1);
    chk("under_addr", ret_addr, 0);
`ifdef STACK_FAULT_EN
    chk("under_pc_en", pc_en, 0);
`else
    chk("under_pc_en", pc_en, 1);
`endif
    step(OP_NOP, 0, 0, 0, 0);
    chk("under_sp", sp_count, 0);
`ifdef STACK_FAULT_EN
    chk("under_fault", fault, 1);
    chk("under_state_pc_en", pc_en, 0);
`else
    chk("under_fault", fault, 0);
    chk("under_state_pc_en", pc_en, 1);
`endif
    step(OP_NOP, 0, 0, 1, 0);
    chk("rst2_pc_en", pc_en, 0);

    for (int i = 0; i < 9; i++) begin
      step(OP_JAL, 0, 0, 0, PCW'(16 + i));
      chk("ovf_sp_pre", sp_count, i);
    end
`ifdef STACK_FAULT_EN
    chk("ovf_jal_pc_en", pc_en, 0);
`else
    chk("ovf_jal_pc_en", pc_en, 1);
    chk("ovf_jal_sinc", s_inc, 0);
`endif
    step(OP_NOP, 0, 0, 0, 0);
    chk("ovf_sp", sp_count, DEPTH);
    chk("ovf_top", ret_addr, 16 + 7);
`ifdef STACK_FAULT_EN
    chk("ovf_fault", fault, 1);
    chk("ovf_pc_en", pc_en, 0);
    step(OP_ALU, 0, 0, 0, 0);
    chk("fault_we3", we3, 0);
    chk("fault_sp", sp_count, DEPTH);
`else
    chk("ovf_fault", fault, 0);
    chk("ovf_pc_en", pc_en, 1);
`endif
    step(OP_NOP, 0, 0, 1, 0);
    step(OP_NOP, 0, 0, 0, 0);
    chk("rst3_sp", sp_count, 0);
    chk("rst3_fault", fault, 0);
    chk("rst3_pc_en", pc_en, 1);

    step(OP_WT, 0, 0, 0, 0);
    chk("wait0_req", io_req, 1);
    chk("wait0_pc_en", pc_en, 0);
    for (int i = 0; i < 3; i++) begin
      step(OP_ALU, 0, 0, 0, 0);
      chk("wait_req", io_req, 1);
      chk("wait_pc_en", pc_en, 0);
      chk("wait_we3", we3, 0);
    end
    step(OP_ALU, 0, 1, 0, 0);
    chk("ack_pc_en", pc_en, 1);
    chk("ack_sinc", s_inc, 1);
    chk("ack_we3", we3, 0);
    step(OP_ALU, 0, 1, 0, 0);
    chk("run_after_ack_we3", we3, 1);
    chk("run_ack_ignored_req", io_req, 0);
    chk("run_ack_pc_en", pc_en, 1);

    step(OP_WT, 0, 0, 0, 0);
    step(OP_NOP, 0, 0, 0, 0);
    chk("wait2_req", io_req, 1);
    step(OP_NOP, 0, 0, 1, 0);
    chk("rst_wait_req", io_req, 0);
    chk("rst_wait_pc_en", pc_en, 0);
    step(OP_NOP, 0, 0, 0, 0);
    chk("post_rst_req", io_req, 0);
    chk("post_rst_pc_en", pc_en, 1);

    step(OP_HLT, 0, 0, 0, 0);
    chk("halt_pc_en", pc_en, 0);
    step(OP_ALU, 0, 0, 0, 0);
    chk("halt_alu_pc_en", pc_en, 0);
    chk("halt_alu_we3", we3, 0);
    step(OP_JAL, 0, 0, 0, 10'h123);
    chk("halt_jal_pc_en", pc_en, 0);
    step(OP_WT, 0, 1, 0, 0);
    chk("halt_sp", sp_count, 0);
    chk("halt_req", io_req, 0);
    step(OP_NOP, 0, 0, 1, 0);
    step(OP_ALU, 0, 0, 0, 0);
    chk("post_halt_we3", we3, 1);
    chk("post_halt_pc_en", pc_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
